moore_seq_detector_param: RTL
=============================

# moore_seq_detector_param

Parametrised Moore sequence detector: the next generation of the team's fixed 1010 detector. It generalises pattern length, supports a runtime-programmable pattern, selects overlapping or non-overlapping detection, gates input with a valid strobe, and keeps a saturating match counter. It sits on a serial bit stream after the deserialiser front-end and flags framing or sync patterns to downstream control logic.

## Interface
Parameters:
- WIDTH, 4, pattern length in bits; legal range 2..16.
- PATTERN, 4'b1010, reset-time pattern, WIDTH bits; MSB is the first bit expected on the line.
- OVERLAP, 1, 1 = overlapping detection, 0 = non-overlapping.
- CNT_W, 8, width of match_count.

Ports (clock and reset first):
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  reset; synchronous, active-low.
- data_valid  input  1  when 1, data is consumed at this edge.
- data  input  1  serial input bit.
- cfg_load  input  1  when 1, loads cfg_pattern and clears progress and count.
- cfg_pattern  input  WIDTH  new pattern, MSB first.
- pattern_detected  output  1  Moore output; 1 while the FSM is in DETECT.
- match_depth  output  $clog2(WIDTH+1)  prefix bits currently matched, 0..WIDTH.
- match_count  output  CNT_W  number of detections, saturating.

## Operation
- Registered state: active pattern (WIDTH bits), match depth d (0..WIDTH), match_count. d == WIDTH is the DETECT state.
- Moore rule: pattern_detected = (d == WIDTH). It is decoded from the registered state only, with no path from data or data_valid.
- Reset (rst == 0 at an edge): active pattern <= PATTERN, d <= 0, match_count <= 0. rst overrides cfg_load and data_valid.
- cfg_load == 1 (rst high): active pattern <= cfg_pattern, d <= 0, match_count <= 0. data is ignored at that edge, even if data_valid is high.
- data_valid == 1 (no reset, no load): d_next is the length of the longest prefix of the active pattern that is a suffix of the accepted-bit history, capped at WIDTH. This is KMP-style fallback, not a plain reset to 0 on mismatch.
  - From d < WIDTH, history is the bits matched so far plus the new bit.
  - From DETECT with OVERLAP=1, history is the full matched pattern plus the new bit. d_next is at most WIDTH-1 unless the pattern is self-overlapping at shift 1, for example all-ones.
  - From DETECT with OVERLAP=0, history is cleared first. d_next = 1 if the new bit equals pattern[WIDTH-1], else 0.
- data_valid == 0: state holds. DETECT is held until the next accepted bit, so pattern_detected can stay high for several cycles.
- match_count increments by 1 on every transition into DETECT, including DETECT->DETECT re-entry with OVERLAP=1. It saturates at 2^CNT_W-1 and does not wrap.
- match_depth = d.

## Timing
- Latency: pattern_detected rises in the cycle after the edge that accepts the final pattern bit (1 clock).
- match_count updates at the same edge that d enters DETECT.
- Reset values: pattern_detected 0, match_depth 0, match_count 0. All take effect at the first rising edge with rst == 0. Reset mid-match discards progress without counting.
- cfg_load mid-match: the match is discarded. pattern_detected is 0 from the next cycle and the count clears. A load while in DETECT drops the output after 1 cycle.
- Back-to-back valid bits are accepted every cycle, with no stall or backpressure.
- With a self-overlapping pattern and OVERLAP=1, pattern_detected can stay high across consecutive accepted bits. The count increments on each entry.

## Test plan
- Reset, then PATTERN=1010, OVERLAP=1, stream 1,0,1,0 with data_valid high every cycle -> pattern_detected=1 in the cycle after the 4th bit, match_count=1. Bits 1,0 continue -> second detection after bit 6, match_count=2.
- OVERLAP=0, stream 1,0,1,0,1,0,1,0 -> detections only after bits 4 and 8, match_count=2. After bit 6, match_depth=2 with no pulse.
- KMP fallback: pattern 1100, stream 1,1,1,0,0 -> match_depth runs 1,2,2,3,4 and detects after bit 5. A naive reset-to-0 detector would miss this.
- Gaps: 1010 delivered with data_valid low for 3 cycles between each bit -> one detection. DETECT is held with pattern_detected=1 until the next valid bit; depth does not change during gaps.
- cfg_load of 0110 after 1,0,1 -> match_depth=0 and count=0 next cycle. Stream 0,1,1,0 then detects. Reset (rst=0) asserted during depth 3 -> all outputs 0 next cycle and pattern reverts to 1010.
- CNT_W=2, pattern 11, OVERLAP=1, stream 1 × 6 -> count goes 1,2,3,3,3 (saturates). pattern_detected stays high from the cycle after bit 2 onward.

Source files
------------

// File: rtl/moore_seq_detector_param.sv
// Parametrised Moore sequence detector with a runtime-loadable pattern, selectable
// overlapping detection, valid-gated input and a saturating match counter.
module moore_seq_detector_param #(
  parameter int              WIDTH   = 4,
  parameter logic [WIDTH-1:0] PATTERN = 4'b1010,
  parameter int              OVERLAP = 1,
  parameter int              CNT_W   = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       data_valid,
  input  logic                       data,
  input  logic                       cfg_load,
  input  logic [WIDTH-1:0]           cfg_pattern,
  output logic                       pattern_detected,
  output logic [$clog2(WIDTH+1)-1:0] match_depth,
  output logic [CNT_W-1:0]           match_count
);

  localparam int DW = $clog2(WIDTH + 1);

  localparam logic [DW-1:0] S_IDLE   = '0;
  localparam logic [DW-1:0] S_DETECT = DW'(WIDTH);

  logic [WIDTH-1:0] pattern_q;
  logic [DW-1:0]    depth_q;
  logic [CNT_W-1:0] count_q;
  logic [DW-1:0]    depth_eff;
  logic [DW-1:0]    depth_next;
  logic [DW-1:0]    next_tbl [0:WIDTH][0:1];

  // Longest pattern prefix that is a suffix of (first dd pattern bits, then b).
  // Pattern bit i in line order is p[WIDTH-1-i].
  function automatic logic [DW-1:0] next_depth(input logic [WIDTH-1:0] p,
                                               input int dd,
                                               input logic b);
    logic [DW-1:0] best;
    logic          ok;
    best = '0;
    for (int k = 1; k <= WIDTH && k <= dd + 1; k++) begin
      ok = (p[WIDTH-k] == b);
      for (int j = 0; j < k - 1; j++) begin
        if (p[WIDTH-1-j] != p[WIDTH-2-dd+k-j]) ok = 1'b0;
      end
      if (ok) best = DW'(k);
    end
    return best;
  endfunction

  // Non-overlapping mode forgets the completed match before taking the next bit.
  always_comb begin
    depth_eff = depth_q;
    if (OVERLAP == 0 && depth_q == S_DETECT) depth_eff = S_IDLE;
    for (int dd = 0; dd <= WIDTH; dd++) begin
      for (int b = 0; b < 2; b++) begin
        next_tbl[dd][b] = next_depth(pattern_q, dd, b[0]);
      end
    end
    depth_next = next_tbl[depth_eff][data];
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      pattern_q <= PATTERN;
      depth_q   <= S_IDLE;
      count_q   <= '0;
    end else if (cfg_load) begin
      pattern_q <= cfg_pattern;
      depth_q   <= S_IDLE;
      count_q   <= '0;
    end else if (data_valid) begin
      depth_q <= depth_next;
      if (depth_next == S_DETECT && count_q != '1) count_q <= count_q + 1'b1;
    end
  end

  assign pattern_detected = (depth_q == S_DETECT);
  assign match_depth      = depth_q;
  assign match_count      = count_q;

endmodule
